// File: rtl/ws281x_pkg.sv
// Shared types and constants for the WS281x line blocks.
// The RX side writes pixels in the same GRB layout that the TX side reads.
package ws281x_pkg;

   localparam int PIX_W      = 24;
   localparam int DEF_ADDR_W = 6;

   typedef enum logic [1:0] {
      ST_ARM,
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } rx_state_e;

endpackage

// File: rtl/ws281x_rx_sync.sv
// Multi-flop synchronizer for an asynchronous line input.
// Also produces single-cycle rise/fall pulses on the synchronized level.
module ws281x_rx_sync #(
   parameter int SYNC_STG = 2
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic din_in,
   output logic din_s,
   output logic rise,
   output logic fall
);

   logic [SYNC_STG-1:0] sync_q;
   logic                din_d;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync_q <= '0;
         din_d  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STG-2:0], din_in};
         din_d  <= din_s;
      end
   end

   assign din_s = sync_q[SYNC_STG-1];
   assign rise  = din_s & ~din_d;
   assign fall  = ~din_s & din_d;

endmodule

// File: rtl/ws281x_rx.sv
// WS281x single-wire receiver: times high pulses into bits, packs them MSB-first
// into 24-bit pixels and writes them to pixel RAM; a long low gap ends the frame.
module ws281x_rx
   import ws281x_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int SYNC_STG = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              din_in,
   input  logic [CNT_W-1:0]  thr_cnt_in,
   input  logic [CNT_W-1:0]  rst_cnt_in,
   output logic              wr_en_out,
   output logic [ADDR_W-1:0] wr_addr_out,
   output logic [PIX_W-1:0]  wr_data_out,
   output logic              frame_done_out,
   output logic [ADDR_W:0]   pix_cnt_out,
   output logic              err_out
);

   localparam logic [ADDR_W:0] PIX_MAX  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [4:0]      BITS_PIX = 5'(PIX_W);

   logic             din_s, rise, fall;
   rx_state_e        state, state_nxt;
   logic [CNT_W-1:0] high_cnt, low_cnt;
   logic [PIX_W-1:0] sh;
   logic [4:0]       bit_cnt;
   logic [ADDR_W:0]  pix_cnt;
   logic             bit_ev, stuck, eof, arm_done;

   ws281x_rx_sync #(.SYNC_STG(SYNC_STG)) u_sync (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .din_in (din_in),
      .din_s  (din_s),
      .rise   (rise),
      .fall   (fall)
   );

   always_comb begin
      state_nxt = state;
      bit_ev    = 1'b0;
      stuck     = 1'b0;
      eof       = 1'b0;
      arm_done  = 1'b0;
      unique case (state)
         ST_ARM:
            if (!din_s && low_cnt == rst_cnt_in) begin
               arm_done  = 1'b1;
               state_nxt = ST_IDLE;
            end
         ST_IDLE:
            if (rise) state_nxt = ST_HIGH;
         ST_HIGH:
            if (fall) begin
               bit_ev    = 1'b1;
               state_nxt = ST_LOW;
            end else if (&high_cnt) begin
               stuck     = 1'b1;
               state_nxt = ST_ARM;
            end
         ST_LOW:
            if (rise) begin
               state_nxt = ST_HIGH;
            end else if (low_cnt == rst_cnt_in) begin
               eof       = 1'b1;
               state_nxt = ST_IDLE;
            end
         default: state_nxt = ST_ARM;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state    <= ST_ARM;
         high_cnt <= '0;
         low_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (rise && (state == ST_IDLE || state == ST_LOW))
            high_cnt <= CNT_W'(1);
         else if (state == ST_HIGH && !(&high_cnt))
            high_cnt <= high_cnt + CNT_W'(1);
         unique case (state)
            ST_ARM:  low_cnt <= din_s ? '0 : ((&low_cnt) ? low_cnt : low_cnt + CNT_W'(1));
            ST_HIGH: low_cnt <= fall ? CNT_W'(1) : '0;
            ST_LOW:  low_cnt <= (&low_cnt) ? low_cnt : low_cnt + CNT_W'(1);
            default: low_cnt <= low_cnt;
         endcase
      end
   end

   // A completed pixel is flushed the cycle after its 24th bit, while the line is low.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sh             <= '0;
         bit_cnt        <= '0;
         pix_cnt        <= '0;
         wr_en_out      <= 1'b0;
         wr_addr_out    <= '0;
         wr_data_out    <= '0;
         frame_done_out <= 1'b0;
         pix_cnt_out    <= '0;
         err_out        <= 1'b0;
      end else begin
         wr_en_out      <= 1'b0;
         frame_done_out <= 1'b0;
         if (bit_ev) begin
            sh      <= {sh[PIX_W-2:0], (high_cnt > thr_cnt_in)};
            bit_cnt <= bit_cnt + 5'd1;
         end else if (bit_cnt == BITS_PIX) begin
            bit_cnt <= '0;
            if (pix_cnt == PIX_MAX) begin
               err_out <= 1'b1;
            end else begin
               wr_en_out   <= 1'b1;
               wr_addr_out <= pix_cnt[ADDR_W-1:0];
               wr_data_out <= sh;
               pix_cnt     <= pix_cnt + (ADDR_W+1)'(1);
            end
         end else if (eof) begin
            if (bit_cnt != '0) err_out <= 1'b1;
            if (pix_cnt != '0) begin
               frame_done_out <= 1'b1;
               pix_cnt_out    <= pix_cnt;
            end
            pix_cnt <= '0;
            bit_cnt <= '0;
         end else if (arm_done) begin
            // re-sync after reset or stuck line: drop whatever was half-built
            pix_cnt <= '0;
            bit_cnt <= '0;
         end
         if (stuck) err_out <= 1'b1;
      end
   end

endmodule
